// File: rtl/compare_seq.sv
// rtl/compare_seq.sv - operand register / settle / capture sequencer for an external compare stage
//
// Purpose:
//    Accepts an operand pair over a valid/ready handshake and registers it onto
//    cmp_a/cmp_b, which feed an external combinational compare stage. The pair
//    is held for SETTLE cycles so the compare stage can settle. On the last of
//    those cycles the compare result (cmp_out) is captured into res_out. The
//    result is then offered downstream until res_ready is seen.
//
//    Timing, for an accept at rising edge N:
//       edge N          : cmp_a/cmp_b load, state -> SETTLE
//       edge N+SETTLE   : res_out loads cmp_out, state -> DONE (res_valid high)
//       edge with res_ready in DONE : state -> IDLE, op_count increments
//    The earliest next accept is the edge after the return to IDLE, which
//    gives a peak rate of one operation every SETTLE+2 cycles.
//
// Parameters:
//    WIDTH   operand and result width in bits
//    SETTLE  cycles the operands are held before capture (0 behaves as 1)
//
// Ports:
//    clk        in   sole clock, rising edge
//    rst_n      in   asynchronous active-low reset
//    in_valid   in   operand pair valid
//    in_ready   out  block can accept an operand pair (IDLE and out of reset)
//    in_a       in   operand a
//    in_b       in   operand b
//    cmp_a      out  registered operand a to the compare stage
//    cmp_b      out  registered operand b to the compare stage
//    cmp_out    in   combinational result from the compare stage
//    res_valid  out  captured result available (DONE)
//    res_ready  in   downstream accepts the result
//    res_out    out  captured compare result
//    op_count   out  completed operations, modulo 256
//    busy       out  high in any state other than IDLE

module compare_seq #(
   parameter int WIDTH  = 4,
   parameter int SETTLE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic [WIDTH-1:0] cmp_a,
   output logic [WIDTH-1:0] cmp_b,
   input  logic [WIDTH-1:0] cmp_out,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_out,
   output logic [7:0]       op_count,
   output logic             busy
);

   // A settle time of zero would leave no cycle for the compare stage to
   // see the new operands, so it is promoted to one.
   localparam int SETTLE_EFF = (SETTLE < 1) ? 1 : SETTLE;

   // Counter only needs to hold SETTLE_EFF down to 1.
   localparam int CW = (SETTLE_EFF < 2) ? 1 : $clog2(SETTLE_EFF + 1);

   localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_EFF);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nx;
   logic [CW-1:0]   cnt;

   // Single-cycle strobes decoded from the current state and handshakes.
   logic            accept;    // operand pair taken this edge
   logic            capture;   // compare result sampled this edge
   logic            retire;    // result handed downstream this edge

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // ------------------------------------------------------------------
   // Next-state and output decode
   // ------------------------------------------------------------------
   always_comb begin
      state_nx  = state;
      accept    = 1'b0;
      capture   = 1'b0;
      retire    = 1'b0;
      in_ready  = 1'b0;
      res_valid = 1'b0;
      busy      = 1'b1;

      case (state)
         ST_IDLE: begin
            busy = 1'b0;
            // Gate with rst_n so in_ready reads 0 for the whole reset
            // interval, not only after the first clock edge.
            in_ready = rst_n;
            if (in_valid) begin
               accept   = 1'b1;
               state_nx = ST_SETTLE;
            end
         end

         ST_SETTLE: begin
            // The edge that sees the counter at one is the SETTLE-th edge
            // after the accept; capture on it.
            if (cnt == CNT_ONE) begin
               capture  = 1'b1;
               state_nx = ST_DONE;
            end
         end

         ST_DONE: begin
            res_valid = 1'b1;
            // in_valid is deliberately not looked at here: a new pair can
            // only be accepted from IDLE, one edge after the retire.
            if (res_ready) begin
               retire   = 1'b1;
               state_nx = ST_IDLE;
            end
         end

         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Operand registers: only written on an accept, so they hold the last
   // accepted pair through SETTLE, DONE and the following IDLE, and
   // in_a/in_b are never sampled outside an accept.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmp_a <= '0;
         cmp_b <= '0;
      end else if (accept) begin
         cmp_a <= in_a;
         cmp_b <= in_b;
      end
   end

   // ------------------------------------------------------------------
   // Settle counter
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (accept) begin
         cnt <= CNT_LOAD;
      end else if (state == ST_SETTLE && !capture) begin
         cnt <= cnt - CNT_ONE;
      end
   end

   // ------------------------------------------------------------------
   // Result register: cmp_out is sampled only on the capture edge, so the
   // value it carries at any other time has no effect.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_out <= '0;
      end else if (capture) begin
         res_out <= cmp_out;
      end
   end

   // ------------------------------------------------------------------
   // Completed-operation counter, wraps 255 -> 0 by natural overflow.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_count <= 8'd0;
      end else if (retire) begin
         op_count <= op_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_compare_seq.sv
// tb/tb_compare_seq.sv - self-checking bench for compare_seq (SETTLE = 1, 3 and 0 side by side)

module tb_compare_seq;

   localparam int W = 4;
   localparam int N = 3;
   localparam int SV [N] = '{1, 3, 0};

   logic clk;
   logic rst_n;
   logic in_valid;
   logic res_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic [W-1:0] cmp_out;

   logic         in_ready_w  [N];
   logic         res_valid_w [N];
   logic         busy_w      [N];
   logic [W-1:0] cmpa_w      [N];
   logic [W-1:0] cmpb_w      [N];
   logic [W-1:0] res_w       [N];
   logic [7:0]   op_w        [N];

   int errors = 0;
   int checks = 0;

   compare_seq #(.WIDTH(W), .SETTLE(SV[0])) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[0]),
      .in_a(in_a), .in_b(in_b), .cmp_a(cmpa_w[0]), .cmp_b(cmpb_w[0]),
      .cmp_out(cmp_out), .res_valid(res_valid_w[0]), .res_ready(res_ready),
      .res_out(res_w[0]), .op_count(op_w[0]), .busy(busy_w[0]));

   compare_seq #(.WIDTH(W), .SETTLE(SV[1])) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[1]),
      .in_a(in_a), .in_b(in_b), .cmp_a(cmpa_w[1]), .cmp_b(cmpb_w[1]),
      .cmp_out(cmp_out), .res_valid(res_valid_w[1]), .res_ready(res_ready),
      .res_out(res_w[1]), .op_count(op_w[1]), .busy(busy_w[1]));

   compare_seq #(.WIDTH(W), .SETTLE(SV[2])) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[2]),
      .in_a(in_a), .in_b(in_b), .cmp_a(cmpa_w[2]), .cmp_b(cmpb_w[2]),
      .cmp_out(cmp_out), .res_valid(res_valid_w[2]), .res_ready(res_ready),
      .res_out(res_w[2]), .op_count(op_w[2]), .busy(busy_w[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int seff(input int k);
      return (SV[k] < 1) ? 1 : SV[k];
   endfunction

   // ------------------------------------------------------------------
   // Reference model: transaction timeline. Each instance is either free
   // or holds one operation accepted at edge macc; its result is sampled
   // at edge macc+S and it may retire on any later edge with res_ready.
   // ------------------------------------------------------------------
   int           e;
   bit           mbusy  [N];
   int           macc   [N];
   logic [W-1:0] ma     [N];
   logic [W-1:0] mb     [N];
   logic [W-1:0] mres   [N];
   logic [7:0]   mop    [N];
   int           tot    [N];
   int           prev   [N];
   bit           have_prev [N];
   bit           b2b;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e = 0;
         for (int k = 0; k < N; k++) begin
            mbusy[k] = 0; macc[k] = 0; ma[k] = '0; mb[k] = '0;
            mres[k] = '0; mop[k] = 8'd0; tot[k] = 0; have_prev[k] = 0;
         end
      end else begin
         e = e + 1;
         for (int k = 0; k < N; k++) begin
            if (!mbusy[k]) begin
               if (in_valid) begin
                  if (b2b && have_prev[k])
                     chk($sformatf("spacing[%0d]", k), e - prev[k], seff(k) + 2);
                  prev[k] = e; have_prev[k] = 1;
                  mbusy[k] = 1; macc[k] = e; ma[k] = in_a; mb[k] = in_b;
               end
            end else if (e - macc[k] == seff(k)) begin
               mres[k] = cmp_out;
            end else if (e - macc[k] > seff(k) && res_ready) begin
               mbusy[k] = 0;
               mop[k] = mop[k] + 8'd1;
               tot[k] = tot[k] + 1;
            end
         end
      end
   end

   // Compare process: every output of every instance, every cycle.
   always @(negedge clk) begin
      for (int k = 0; k < N; k++) begin
         logic exp_rv;
         exp_rv = mbusy[k] && (e - macc[k] >= seff(k));
         chk($sformatf("in_ready[%0d]", k),  in_ready_w[k],  !mbusy[k] && rst_n);
         chk($sformatf("res_valid[%0d]", k), res_valid_w[k], exp_rv);
         chk($sformatf("busy[%0d]", k),      busy_w[k],      mbusy[k]);
         chk($sformatf("cmp_a[%0d]", k),     cmpa_w[k],      ma[k]);
         chk($sformatf("cmp_b[%0d]", k),     cmpb_w[k],      mb[k]);
         chk($sformatf("res_out[%0d]", k),   res_w[k],       mres[k]);
         chk($sformatf("op_count[%0d]", k),  op_w[k],        mop[k]);
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      int cyc;
      rst_n = 0; in_valid = 0; in_a = '0; in_b = '0; cmp_out = '0;
      res_ready = 0; b2b = 0;
      repeat (3) tick();
      #1;
      chk("rst_in_ready", in_ready_w[0], 0);
      chk("rst_op_count", op_w[0], 0);
      chk("rst_res_valid", res_valid_w[1], 0);

      // Release: ready in the first cycle.
      rst_n = 1;
      #1 chk("rel_in_ready", in_ready_w[0], 1);

      // SETTLE=1 basic operation.
      in_valid = 1; in_a = 4'b0011; in_b = 4'b0001; cmp_out = 4'b0100;
      tick();
      in_valid = 0;
      #1 chk("s1_busy", busy_w[0], 1);
      chk("s1_not_yet", res_valid_w[0], 0);
      tick();
      #1 chk("s1_res_valid", res_valid_w[0], 1);
      chk("s1_res_out", res_w[0], 4'b0100);
      res_ready = 1;
      tick();
      #1 chk("s1_op_count", op_w[0], 1);
      chk("s1_idle", in_ready_w[0], 1);
      repeat (3) tick();
      res_ready = 0;

      // Result held with res_ready low; extra in_valid ignored.
      in_valid = 1; in_a = 4'b0000; in_b = 4'b0111;
      tick();
      in_valid = 0; cmp_out = 4'b0101;
      repeat (3) tick();
      in_valid = 1; in_a = 4'b1001; in_b = 4'b1001;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("hold_res_out", res_w[1], 4'b0101);
         chk("hold_cmp_a", cmpa_w[1], 4'b0000);
         chk("hold_in_ready", in_ready_w[1], 0);
         chk("hold_res_valid", res_valid_w[1], 1);
         tick();
      end
      res_ready = 1;
      tick();
      #1 chk("same_cycle_not_acc", cmpa_w[1], 4'b0000);
      chk("retire_idle", in_ready_w[1], 1);
      res_ready = 0;
      tick();
      #1 chk("next_idle_acc", cmpa_w[1], 4'b1001);
      in_valid = 0; res_ready = 1;
      repeat (6) tick();
      res_ready = 0;

      // SETTLE=3 with cmp_out changing during the second settle cycle.
      in_valid = 1; in_a = 4'b0001; in_b = 4'b0001; cmp_out = 4'b0000;
      tick();
      in_valid = 0;
      tick();
      cmp_out = 4'b0010;
      tick();
      #1 chk("s3_not_yet", res_valid_w[1], 0);
      tick();
      #1 chk("s3_res_valid", res_valid_w[1], 1);
      chk("s3_res_out", res_w[1], 4'b0010);
      res_ready = 1;
      repeat (3) tick();
      res_ready = 0;

      // Reset during SETTLE.
      in_valid = 1; in_a = 4'b0101; in_b = 4'b0110;
      tick();
      in_valid = 0;
      tick();
      #1 rst_n = 0;
      #1;
      chk("arst_busy", busy_w[1], 0);
      chk("arst_cmp_a", cmpa_w[1], 0);
      chk("arst_res_valid", res_valid_w[1], 0);
      chk("arst_op_count", op_w[1], 0);
      chk("arst_in_ready", in_ready_w[1], 0);
      chk("arst_res_out", res_w[1], 0);
      repeat (2) tick();
      in_valid = 1; in_a = 4'b1010; in_b = 4'b0011;
      rst_n = 1;
      tick();
      #1 chk("post_rst_acc", busy_w[1], 1);
      chk("post_rst_cmp_a", cmpa_w[1], 4'b1010);
      in_valid = 0; res_ready = 1;
      repeat (5) tick();

      // Randomized traffic; operands driven X while not offered.
      for (int i = 0; i < 800; i++) begin
         in_valid  = 1'($urandom_range(0, 1));
         in_a      = in_valid ? W'($urandom) : 'x;
         in_b      = in_valid ? W'($urandom) : 'x;
         cmp_out   = W'($urandom);
         res_ready = ($urandom_range(0, 9) < 6);
         if ($urandom_range(0, 149) == 0) begin
            rst_n = 0;
            tick();
            rst_n = 1;
         end
         tick();
      end

      // Back-to-back with res_ready tied high: spacing and op_count wrap.
      rst_n = 0; in_valid = 0; res_ready = 0; in_a = '0; in_b = '0;
      tick();
      b2b = 1; in_valid = 1; res_ready = 1; rst_n = 1;
      cyc = 0;
      while (tot[1] < 256 && cyc < 3000) begin
         in_a = W'($urandom); in_b = W'($urandom); cmp_out = W'($urandom);
         tick();
         cyc++;
      end
      chk("wrap_reached", tot[1], 256);
      #1 chk("wrap_op_count", op_w[1], 0);
      in_valid = 0; b2b = 0;
      repeat (6) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
